// File: rtl/painter_pkg.sv
// Shared encodings and colour helpers for the screen painter.
package painter_pkg;

  localparam int unsigned MODE_W  = 2;
  localparam int unsigned STATE_W = 2;

  // Draw modes as presented on the mode input.
  typedef enum logic [MODE_W-1:0] {
    MODE_CLEAR     = 2'd0,
    MODE_KEYS      = 2'd1,
    MODE_HIGHLIGHT = 2'd2,
    MODE_CHECKER   = 2'd3
  } mode_e;

  // Frame sequencing states.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // All-ones colour for a given colour width (saturates at 32 bits).
  function automatic logic [31:0] white_of(int unsigned w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // All-zeros colour for a given colour width.
  function automatic logic [31:0] black_of(int unsigned w);
    return white_of(w) & 32'h0;
  endfunction

endpackage

// File: rtl/raster_scan.sv
// Row-major pixel scanner with per-key column and key index tracking.
module raster_scan
  import painter_pkg::*;
#(
  parameter int unsigned H_RES  = 160,
  parameter int unsigned V_RES  = 120,
  parameter int unsigned KEY_W  = 20,
  parameter int unsigned X_W    = 8,
  parameter int unsigned Y_W    = 7,
  parameter int unsigned COL_W  = 5,
  parameter int unsigned KIDX_W = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              clear,
  input  logic              advance,
  output logic [X_W-1:0]    px,
  output logic [Y_W-1:0]    py,
  output logic [COL_W-1:0]  col,
  output logic [KIDX_W-1:0] kidx,
  output logic              last_c
);

  logic x_wrap_c;
  logic y_wrap_c;
  logic col_wrap_c;
  logic kidx_sat_c;

  // Wrap and end-of-frame detection on the current position.
  always_comb begin
    x_wrap_c   = (px == X_W'(H_RES - 1));
    y_wrap_c   = (py == Y_W'(V_RES - 1));
    col_wrap_c = (col == COL_W'(KEY_W - 1));
    kidx_sat_c = (kidx == {KIDX_W{1'b1}});
    last_c     = x_wrap_c && y_wrap_c;
  end

  // Position counters; advance wins over clear, key counters restart at each row.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      px   <= '0;
      py   <= '0;
      col  <= '0;
      kidx <= '0;
    end else if (advance) begin
      if (x_wrap_c) begin
        px   <= '0;
        col  <= '0;
        kidx <= '0;
        py   <= y_wrap_c ? '0 : py + Y_W'(1);
      end else begin
        px <= px + X_W'(1);
        if (col_wrap_c) begin
          col <= '0;
          if (!kidx_sat_c) kidx <= kidx + KIDX_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end
    end else if (clear) begin
      px   <= '0;
      py   <= '0;
      col  <= '0;
      kidx <= '0;
    end
  end

endmodule

// File: rtl/screen_painter.sv
// Full-screen draw engine feeding the vga_adapter pixel-write port.
module screen_painter
  import painter_pkg::*;
#(
  parameter int unsigned H_RES    = 160,
  parameter int unsigned V_RES    = 120,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned COLOUR_W = 3,
  parameter int unsigned KEY_W    = 20,
  parameter int unsigned NUM_KEYS = 8,
  parameter int unsigned BLACK_H  = 72
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        abort,
  input  logic [1:0]                  mode,
  input  logic [$clog2(NUM_KEYS)-1:0] key_sel,
  input  logic [COLOUR_W-1:0]         fill_colour,
  output logic [X_W-1:0]              x,
  output logic [Y_W-1:0]              y,
  output logic [COLOUR_W-1:0]         colour,
  output logic                        plot,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned SEL_W    = $clog2(NUM_KEYS);
  localparam int unsigned COL_W    = $clog2(KEY_W);
  localparam int unsigned KIDX_W   = $clog2(H_RES / KEY_W + 1);
  localparam int unsigned KEYS_END = NUM_KEYS * KEY_W;
  localparam int unsigned BKEY_W   = KEY_W / 4;
  localparam logic [COLOUR_W-1:0] WHITE = COLOUR_W'(white_of(COLOUR_W));
  localparam logic [COLOUR_W-1:0] BLACK = COLOUR_W'(black_of(COLOUR_W));

  state_e              state, state_d;
  mode_e               mode_q, eff_mode;
  logic [SEL_W-1:0]    sel_q, eff_sel;
  logic [COLOUR_W-1:0] fill_q, eff_fill;
  logic                last_q;
  logic                emit_c;
  logic                clear_c;
  logic                key_white;
  logic [COLOUR_W-1:0] pix_colour;
  logic [X_W-1:0]      px, x_d;
  logic [Y_W-1:0]      py, y_d;
  logic [COL_W-1:0]    col;
  logic [KIDX_W-1:0]   kidx;
  logic                last_c;
  logic [COLOUR_W-1:0] colour_d;
  logic                plot_d, busy_d, done_d;

  raster_scan #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .KEY_W (KEY_W),
    .X_W   (X_W),
    .Y_W   (Y_W),
    .COL_W (COL_W),
    .KIDX_W(KIDX_W)
  ) u_scan (
    .clock  (clock),
    .resetn (resetn),
    .clear  (clear_c),
    .advance(emit_c),
    .px     (px),
    .py     (py),
    .col    (col),
    .kidx   (kidx),
    .last_c (last_c)
  );

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_d;
  end

  // Next state and next output values; a pixel is emitted on every DRAW cycle
  // until the last one has gone out or an abort arrives.
  always_comb begin
    state_d  = state;
    emit_c   = 1'b0;
    unique case (state)
      ST_IDLE: if (start) begin
        state_d = ST_DRAW;
        emit_c  = 1'b1;
      end
      ST_DRAW: begin
        if (abort || last_q) state_d = ST_DONE;
        else                 emit_c  = 1'b1;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    clear_c  = (state != ST_DRAW) && !emit_c;
    x_d      = x;
    y_d      = y;
    colour_d = colour;
    plot_d   = 1'b0;
    busy_d   = (state_d == ST_DRAW);
    done_d   = (state_d == ST_DONE);
    if (emit_c) begin
      x_d      = px;
      y_d      = py;
      colour_d = pix_colour;
      plot_d   = 1'b1;
    end
  end

  // Registered pixel-port outputs and the last-pixel-sent flag.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      x      <= x_d;
      y      <= y_d;
      colour <= colour_d;
      plot   <= plot_d;
      busy   <= busy_d;
      done   <= done_d;
      if (emit_c) last_q <= last_c;
    end
  end

  // Frame settings captured when a start is accepted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mode_q <= MODE_CLEAR;
      sel_q  <= '0;
      fill_q <= '0;
    end else if (state == ST_IDLE && start) begin
      mode_q <= mode_e'(mode);
      sel_q  <= key_sel;
      fill_q <= fill_colour;
    end
  end

  // The first pixel is coloured from the live inputs, the rest from the latches.
  always_comb begin
    eff_mode = (state == ST_IDLE) ? mode_e'(mode) : mode_q;
    eff_sel  = (state == ST_IDLE) ? key_sel       : sel_q;
    eff_fill = (state == ST_IDLE) ? fill_colour   : fill_q;
  end

  // Colour mux for the pixel at the scanner position.
  always_comb begin
    key_white = 1'b1;
    if (32'(px) >= KEYS_END)                                        key_white = 1'b0;
    else if (col == COL_W'(KEY_W - 1))                              key_white = 1'b0;
    else if (32'(py) < BLACK_H && 32'(col) < BKEY_W && kidx != '0)  key_white = 1'b0;
    pix_colour = BLACK;
    unique case (eff_mode)
      MODE_CLEAR:     pix_colour = eff_fill;
      MODE_KEYS:      pix_colour = key_white ? WHITE : BLACK;
      MODE_HIGHLIGHT: pix_colour = !key_white ? BLACK :
                                   (32'(kidx) == 32'(eff_sel)) ? eff_fill : WHITE;
      MODE_CHECKER:   pix_colour = (px[2] ^ py[2]) ? eff_fill : BLACK;
      default:        pix_colour = BLACK;
    endcase
  end

endmodule

// File: tb/tb_screen_painter.sv
// Directed self-checking bench for screen_painter.
module tb_screen_painter;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0, abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] key_sel = 3'd0;
  logic [2:0] fill_colour = 3'd0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;

  logic       start2 = 1'b0, abort2 = 1'b0;
  logic [1:0] mode2 = 2'd0;
  logic [2:0] key_sel2 = 3'd0;
  logic [2:0] fill2 = 3'd0;
  logic [7:0] x2;
  logic [6:0] y2;
  logic [2:0] colour2;
  logic       plot2, busy2, done2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  screen_painter dut (
    .clock(clock), .resetn(resetn), .start(start), .abort(abort),
    .mode(mode), .key_sel(key_sel), .fill_colour(fill_colour),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  screen_painter #(.H_RES(176)) dut_wide (
    .clock(clock), .resetn(resetn), .start(start2), .abort(abort2),
    .mode(mode2), .key_sel(key_sel2), .fill_colour(fill2),
    .x(x2), .y(y2), .colour(colour2), .plot(plot2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge where pixel (0,0) should be shown.
  task automatic start_frame(input logic [1:0] m, input logic [2:0] ks, input logic [2:0] fc);
    mode = m; key_sel = ks; fill_colour = fc; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic goto_pixel(input int px, input int py, output logic found);
    found = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (plot === 1'b1 && int'(x) == px && int'(y) == py) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
  endtask

  // Abort the running frame from a negedge and step through DONE back to IDLE.
  task automatic abort_frame(input string tag);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check({tag, "_abort_done"}, {29'd0, plot, busy, done}, 32'h1);
    @(negedge clock);
    check({tag, "_abort_idle"}, {29'd0, plot, busy, done}, 32'h0);
  endtask

  // Observe a frame from its first pixel until one cycle past done.
  task automatic watch_frame(input int retrig_at, input logic [2:0] exp_col,
                             output int plots, output int order_err, output int col_err,
                             output int busy_err, output int dones, output int done_after,
                             output int last_x, output int last_y);
    int ex, ey, cyc, last_plot, done_cyc;
    ex = 0; ey = 0; cyc = 0; last_plot = -1; done_cyc = -1;
    plots = 0; order_err = 0; col_err = 0; busy_err = 0; dones = 0;
    last_x = -1; last_y = -1;
    while (cyc < 25000) begin
      if (plot === 1'b1) begin
        if (int'(x) != ex || int'(y) != ey) order_err++;
        if (colour !== exp_col) col_err++;
        last_x = int'(x); last_y = int'(y);
        plots++; last_plot = cyc;
        ex++;
        if (ex == 160) begin ex = 0; ey++; end
      end
      if (busy !== plot) busy_err++;
      if (done === 1'b1) begin dones++; done_cyc = cyc; end
      if (plots == retrig_at && plot === 1'b1) begin
        start = 1'b1; mode = 2'd3; fill_colour = 3'b000;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      cyc++;
      if (done_cyc >= 0 && cyc > done_cyc + 1) break;
    end
    start = 1'b0;
    done_after = (done_cyc >= 0) ? done_cyc - last_plot : -1;
  endtask

  initial begin
    int plots, order_err, col_err, busy_err, dones, done_after, lx, ly;
    logic found;

    // Reset state
    #12;
    check("rst_outputs", {x, y, colour, plot, busy, done}, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    check("idle_outputs", {x, y, colour, plot, busy, done}, 32'h0);

    // Full CLEAR frame with an ignored re-start at pixel 500
    start_frame(2'd0, 3'd0, 3'b101);
    check("clear_first_px", {12'd0, x, y, colour, plot, busy}, {12'd0, 8'd0, 7'd0, 3'b101, 1'b1, 1'b1});
    watch_frame(500, 3'b101, plots, order_err, col_err, busy_err, dones, done_after, lx, ly);
    check("clear_plots", plots, 19200);
    check("clear_order", order_err, 0);
    check("clear_colour", col_err, 0);
    check("clear_busy", busy_err, 0);
    check("clear_last_x", lx, 159);
    check("clear_last_y", ly, 119);
    check("clear_dones", dones, 1);
    check("clear_done_gap", done_after, 1);
    check("clear_back_idle", {29'd0, plot, busy, done}, 32'h0);

    // KEYS frame
    start_frame(2'd1, 3'd0, 3'b000);
    goto_pixel(19, 0, found);
    check("keys_19_0_seen", found, 1);
    check("keys_19_0", colour, 3'b000);
    goto_pixel(0, 10, found);
    check("keys_0_10_seen", found, 1);
    check("keys_0_10", colour, 3'b111);
    goto_pixel(20, 10, found);
    check("keys_20_10_seen", found, 1);
    check("keys_20_10", colour, 3'b000);
    goto_pixel(20, 80, found);
    check("keys_20_80_seen", found, 1);
    check("keys_20_80", colour, 3'b111);
    abort_frame("keys");

    // HIGHLIGHT frame; inputs changed after start must not matter
    start_frame(2'd2, 3'd2, 3'b100);
    key_sel = 3'd1; fill_colour = 3'b011; mode = 2'd0;
    goto_pixel(25, 100, found);
    check("hl_25_100_seen", found, 1);
    check("hl_25_100", colour, 3'b111);
    goto_pixel(45, 100, found);
    check("hl_45_100_seen", found, 1);
    check("hl_45_100", colour, 3'b100);
    goto_pixel(59, 100, found);
    check("hl_59_100_seen", found, 1);
    check("hl_59_100", colour, 3'b000);
    abort_frame("hl");

    // Off-keyboard region on a wider screen
    mode2 = 2'd1; start2 = 1'b1;
    @(negedge clock);
    start2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (plot2 === 1'b1 && x2 == 8'd150 && y2 == 7'd5) check("wide_150_5", colour2, 3'b111);
      if (plot2 === 1'b1 && x2 == 8'd165 && y2 == 7'd5) begin found = 1'b1; break; end
      @(negedge clock);
    end
    check("wide_165_5_seen", found, 1);
    check("wide_165_5", colour2, 3'b000);
    abort2 = 1'b1;
    @(negedge clock);
    abort2 = 1'b0;
    check("wide_abort_done", {29'd0, plot2, busy2, done2}, 32'h1);
    @(negedge clock);

    // Abort at pixel 1000, then restart from the origin
    start_frame(2'd0, 3'd0, 3'b110);
    goto_pixel(40, 6, found);
    check("abort_px1000_seen", found, 1);
    abort_frame("clear");
    start_frame(2'd0, 3'd0, 3'b110);
    check("restart_origin", {13'd0, x, y, plot, busy, done}, {13'd0, 8'd0, 7'd0, 3'b110});

    // Asynchronous reset mid-frame
    goto_pixel(13, 2, found);
    check("rst_px_seen", found, 1);
    @(posedge clock);
    #2 resetn = 1'b0;
    #1 check("rst_async_clear", {x, y, colour, plot, busy, done}, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    dones = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) dones++;
    end
    check("rst_no_done", dones, 0);

    // A full frame after reset
    start_frame(2'd0, 3'd0, 3'b010);
    watch_frame(-1, 3'b010, plots, order_err, col_err, busy_err, dones, done_after, lx, ly);
    check("post_rst_plots", plots, 19200);
    check("post_rst_order", order_err, 0);
    check("post_rst_colour", col_err, 0);
    check("post_rst_dones", dones, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
